uart_rx_ext: RTL and testbench

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It supports configurable data width, optional odd/even parity and one or two stop bits. Each bit is decided by a 3-sample majority vote, and framing, parity and overrun errors are reported. Received words are delivered through a valid/ready holding register, so the block sits between the board RX pin and any back-pressuring consumer (FIFO, command parser).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_ext.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_ext.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive blocks: state encoding, parity modes
// and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line; both flops reset to 1
// so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      meta <= 1'b1;
      o_rx <= 1'b1;
    end else begin
      meta <= i_rx;
      o_rx <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with majority-vote bit decisions, parity/framing
// checks and a valid/ready holding register with overrun reporting.
//
// state   | meaning
// IDLE    | waiting for a falling edge on an armed line
// START   | confirming the start bit at its midpoint
// DATA    | shifting DATA_BITS data bits, LSB first
// PARITY  | capturing the parity bit
// STOP    | checking STOP_BITS stop bits
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 543,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t            state, state_nxt;
  logic                 rx;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           idx;
  logic                 armed;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;

  logic bit_phase, bit_tick, done, bit_val;
  logic frame_err_now, parity_err_now, load;

  uart_rx_sync u_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_rx),
    .o_rx    (rx)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx && armed) state_nxt = ST_START;
      ST_START:  if (cnt == CNT_HALF) state_nxt = rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_tick && idx == IDX_DATA_LAST)
                   state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
      ST_STOP:   if (bit_tick && idx == IDX_STOP_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != ST_IDLE);
    bit_phase = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    bit_tick  = bit_phase && (cnt == CNT_LAST);
    done      = (state == ST_STOP) && bit_tick && (idx == IDX_STOP_LAST);
  end

  // The third vote is the live sample taken on the deciding count.
  assign bit_val       = majority3(samp_a, samp_b, rx);
  assign frame_err_now = stop_err | ~bit_val;

  always_comb begin
    parity_err_now = 1'b0;
    if (PARITY == PARITY_ODD)       parity_err_now = ~(^shreg ^ par_bit);
    else if (PARITY == PARITY_EVEN) parity_err_now = ^shreg ^ par_bit;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  cnt <= '0;
        ST_START: cnt <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
        default:  cnt <= bit_tick ? '0 : cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      idx <= '0;
    end else begin
      case (state)
        ST_DATA: if (bit_tick) idx <= (idx == IDX_DATA_LAST) ? '0 : idx + 4'd1;
        ST_STOP: if (bit_tick) idx <= idx + 4'd1;
        default: idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (bit_phase) begin
      if (cnt == CNT_S0) samp_a <= rx;
      if (cnt == CNT_S1) samp_b <= rx;
    end
  end

  // armed drops after a framing error so a held-low (break) line cannot retrigger.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
      armed    <= 1'b1;
    end else begin
      if (state == ST_IDLE) begin
        stop_err <= 1'b0;
        if (rx) armed <= 1'b1;
      end
      if (bit_tick) begin
        case (state)
          ST_DATA:   shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          ST_PARITY: par_bit <= bit_val;
          ST_STOP:   if (!bit_val) stop_err <= 1'b1;
          default:   ;
        endcase
      end
      if (done && frame_err_now) armed <= 1'b0;
    end
  end

  assign load = done && (!o_valid || i_ready);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= done && !load;
      if (load) begin
        o_valid      <= 1'b1;
        o_data       <= shreg;
        o_parity_err <= parity_err_now;
        o_frame_err  <= frame_err_now;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 instance and a 7E2 instance driven by
// bit-level frame generators and checked against a frame-level model.
module tb_uart_rx_ext;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, rdy0, rdy1;
  logic       v0, pe0, fe0, ov0, b0;
  logic       v1, pe1, fe1, ov1, b1;
  logic [7:0] d0;
  logic [6:0] d1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int data;
    bit perr;
    bit ferr;
    int cyc;
  } word_t;

  word_t got0[$];
  word_t got1[$];
  int ov_cnt0 = 0, ov_cnt1 = 0, busy_cyc0 = 0, valid_cyc0 = 0;

  uart_rx_ext #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_rx(rx0), .o_valid(v0), .i_ready(rdy0),
    .o_data(d0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0), .o_busy(b0)
  );

  uart_rx_ext #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_valid(v1), .i_ready(rdy1),
    .o_data(d1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1), .o_busy(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word (handshake seen just before the consuming edge).
  always @(negedge clk) begin
    if (v0 === 1'b1 && rdy0 === 1'b1) got0.push_back('{int'(d0), pe0, fe0, cyc});
    if (v1 === 1'b1 && rdy1 === 1'b1) got1.push_back('{int'(d1), pe1, fe1, cyc});
    if (ov0 === 1'b1) ov_cnt0++;
    if (ov1 === 1'b1) ov_cnt1++;
    if (b0 === 1'b1) busy_cyc0++;
    if (v0 === 1'b1) valid_cyc0++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic send_frame(input int sel, input int data, input int nbits, input int par,
                            input bit flip, input int nstop, input bit stop_v,
                            input int spike_bit, input int spike_pos);
    bit bits[$];
    int ones;
    bit pb, b;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      b = bit'((data >> i) & 1);
      bits.push_back(b);
      ones += int'(b);
    end
    if (par != 0) begin
      pb = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      bits.push_back(pb ^ flip);
    end
    for (int i = 0; i < nstop; i++) bits.push_back(stop_v);
    for (int i = 0; i < bits.size(); i++) begin
      for (int j = 0; j < C; j++) begin
        set_rx(sel, (i == spike_bit && j == spike_pos) ? ~bits[i] : bits[i]);
        tick();
      end
      set_rx(sel, bits[i]);
    end
  endtask

  task automatic pop_word(input int sel, output word_t w, output bit ok);
    ok = 1'b0;
    w  = '{0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 64; i++) begin
      if ((sel == 0 && got0.size() > 0) || (sel == 1 && got1.size() > 0)) break;
      tick();
    end
    if (sel == 0 && got0.size() > 0) begin
      w = got0.pop_front(); ok = 1'b1;
    end else if (sel == 1 && got1.size() > 0) begin
      w = got1.pop_front(); ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if ({v0, d0, pe0, fe0, ov0, b0} !== 13'd0) begin
      n_fail++; $display("FAIL reset_dut0 got=%b exp=0", {v0, d0, pe0, fe0, ov0, b0});
    end
    n_tests++;
    if ({v1, d1, pe1, fe1, ov1, b1} !== 12'd0) begin
      n_fail++; $display("FAIL reset_dut1 got=%b exp=0", {v1, d1, pe1, fe1, ov1, b1});
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic_8n1();
    word_t w; bit ok; int k;
    got0.delete(); valid_cyc0 = 0; k = cyc;
    send_frame(0, 'hA5, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    pop_word(0, w, ok);
    repeat (2) tick();
    n_tests++;
    if (ok !== 1'b1 || w.data !== 'hA5 || {w.perr, w.ferr} !== 2'b00) begin
      n_fail++; $display("FAIL basic_word ok=%0d data=%0h flags=%b exp data=a5 flags=00", ok, w.data, {w.perr, w.ferr});
    end
    n_tests++;
    if (w.cyc !== k + 1 + 3 + HALF + 9 * C) begin
      n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", w.cyc - k, 1 + 3 + HALF + 9 * C);
    end
    n_tests++;
    if (valid_cyc0 !== 1) begin
      n_fail++; $display("FAIL basic_valid_width got=%0d exp=1", valid_cyc0);
    end
  endtask

  task automatic test_glitch_idle();
    busy_cyc0 = 0; got0.delete();
    rx0 = 1'b0; tick(); rx0 = 1'b1;
    repeat (3 * C) tick();
    n_tests++;
    if (busy_cyc0 !== HALF + 1) begin
      n_fail++; $display("FAIL glitch_busy got=%0d exp=%0d", busy_cyc0, HALF + 1);
    end
    n_tests++;
    if (got0.size() !== 0 || v0 !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_word got=%0d exp=0", got0.size());
    end
  endtask

  task automatic test_random_8n1();
    word_t w; bit ok; int data, gap;
    for (int n = 0; n < 8; n++) begin
      data = int'($urandom_range(255, 0));
      gap  = int'($urandom_range(20, 0));
      repeat (gap) tick();
      send_frame(0, data, 8, 0, 1'b0, 1, 1'b1,
                 int'($urandom_range(8, 1)), int'($urandom_range(C - 1, 0)));
      pop_word(0, w, ok);
      n_tests++;
      if (ok !== 1'b1 || w.data !== data || {w.perr, w.ferr} !== 2'b00) begin
        n_fail++; $display("FAIL random_8n1[%0d] ok=%0d data=%0h flags=%b exp data=%0h flags=00",
                           n, ok, w.data, {w.perr, w.ferr}, data);
      end
    end
  endtask

  task automatic test_parity_7e2();
    word_t w; bit ok; int data, k; bit flip;
    got1.delete();
    k = cyc;
    send_frame(1, 'h55, 7, 2, 1'b0, 2, 1'b1, -1, 0);
    send_frame(1, 'h55, 7, 2, 1'b1, 2, 1'b1, -1, 0);
    pop_word(1, w, ok);
    n_tests++;
    if (ok !== 1'b1 || w.data !== 'h55 || {w.perr, w.ferr} !== 2'b00) begin
      n_fail++; $display("FAIL parity_good ok=%0d data=%0h flags=%b exp data=55 flags=00", ok, w.data, {w.perr, w.ferr});
    end
    n_tests++;
    if (w.cyc !== k + 1 + 3 + HALF + 10 * C) begin
      n_fail++; $display("FAIL parity_latency got=%0d exp=%0d", w.cyc - k, 1 + 3 + HALF + 10 * C);
    end
    pop_word(1, w, ok);
    n_tests++;
    if (ok !== 1'b1 || w.data !== 'h55 || {w.perr, w.ferr} !== 2'b10) begin
      n_fail++; $display("FAIL parity_bad ok=%0d data=%0h flags=%b exp data=55 flags=10", ok, w.data, {w.perr, w.ferr});
    end
    for (int n = 0; n < 4; n++) begin
      data = int'($urandom_range(127, 0));
      flip = bit'($urandom_range(1, 0));
      send_frame(1, data, 7, 2, flip, 2, 1'b1, int'($urandom_range(7, 1)), int'($urandom_range(C - 1, 0)));
      pop_word(1, w, ok);
      n_tests++;
      if (ok !== 1'b1 || w.data !== data || {w.perr, w.ferr} !== {flip, 1'b0}) begin
        n_fail++; $display("FAIL parity_random[%0d] ok=%0d data=%0h flags=%b exp data=%0h flags=%b",
                           n, ok, w.data, {w.perr, w.ferr}, data, {flip, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    got0.delete(); ov_cnt0 = 0; rdy0 = 1'b0;
    send_frame(0, 'h11, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    send_frame(0, 'h22, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    repeat (2) tick();
    n_tests++;
    if (ov_cnt0 !== 1 || v0 !== 1'b1 || d0 !== 8'h11) begin
      n_fail++; $display("FAIL bp_overrun ov=%0d valid=%b data=%0h exp ov=1 valid=1 data=11", ov_cnt0, v0, d0);
    end
    fork
      send_frame(0, 'h33, 8, 0, 1'b0, 1, 1'b1, -1, 0);
      begin
        repeat (3 + HALF + 9 * C) tick();
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
      end
    join
    repeat (2) tick();
    n_tests++;
    if (got0.size() !== 1 || (got0.size() > 0 && got0[0].data !== 'h11)) begin
      n_fail++; $display("FAIL bp_consumed count=%0d exp one word 11", got0.size());
    end
    n_tests++;
    if (v0 !== 1'b1 || d0 !== 8'h33 || ov_cnt0 !== 1) begin
      n_fail++; $display("FAIL bp_reload valid=%b data=%0h ov=%0d exp valid=1 data=33 ov=1", v0, d0, ov_cnt0);
    end
    rdy0 = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (got0.size() !== 2 || v0 !== 1'b0 || (got0.size() > 1 && got0[1].data !== 'h33)) begin
      n_fail++; $display("FAIL bp_drain count=%0d valid=%b exp count=2 valid=0 last=33", got0.size(), v0);
    end
    got0.delete();
  endtask

  task automatic test_break();
    word_t w; bit ok;
    got0.delete(); rdy0 = 1'b1;
    send_frame(0, 'h00, 8, 0, 1'b0, 1, 1'b0, -1, 0);
    busy_cyc0 = 0;
    repeat (40 * C) tick();
    n_tests++;
    if (got0.size() !== 1 || got0[0].data !== 0 || {got0[0].perr, got0[0].ferr} !== 2'b01) begin
      n_fail++; $display("FAIL break_word count=%0d exp one word 00 with frame error", got0.size());
    end
    n_tests++;
    if (busy_cyc0 !== 0) begin
      n_fail++; $display("FAIL break_rearm busy_cycles=%0d exp=0", busy_cyc0);
    end
    got0.delete();
    rx0 = 1'b1;
    repeat (2 * C) tick();
    n_tests++;
    if (got0.size() !== 0) begin
      n_fail++; $display("FAIL break_release count=%0d exp=0", got0.size());
    end
    send_frame(0, 'h5A, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    pop_word(0, w, ok);
    n_tests++;
    if (ok !== 1'b1 || w.data !== 'h5A || {w.perr, w.ferr} !== 2'b00) begin
      n_fail++; $display("FAIL break_recover ok=%0d data=%0h flags=%b exp data=5a flags=00", ok, w.data, {w.perr, w.ferr});
    end
  endtask

  task automatic test_reset_mid();
    word_t w; bit ok;
    rdy0 = 1'b0;
    send_frame(0, 'h77, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    repeat (4) tick();
    // Upper data bits are ones so the tail of the aborted frame cannot look like a start bit.
    fork
      send_frame(0, 'hF5, 8, 0, 1'b0, 1, 1'b1, -1, 0);
      begin
        repeat (82) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({v0, d0, pe0, fe0, ov0, b0} !== 13'd0) begin
          n_fail++; $display("FAIL reset_mid got=%b exp=0", {v0, d0, pe0, fe0, ov0, b0});
        end
      end
    join
    rdy0 = 1'b1;
    repeat (2 * C) tick();
    got0.delete();
    send_frame(0, 'h3C, 8, 0, 1'b0, 1, 1'b1, -1, 0);
    pop_word(0, w, ok);
    n_tests++;
    if (ok !== 1'b1 || w.data !== 'h3C || {w.perr, w.ferr} !== 2'b00) begin
      n_fail++; $display("FAIL reset_recover ok=%0d data=%0h flags=%b exp data=3c flags=00", ok, w.data, {w.perr, w.ferr});
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_glitch_idle();
    test_random_8n1();
    test_parity_7e2();
    test_back_to_back();
    test_break();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
